muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the single-cycle core. It sits between register-file read and writeback: it takes the two source operands read for an M-extension instruction and returns the 32-bit result on the register write-data path. While an operation is in flight it asserts `busy`, and the core stalls the PC and suppresses `reg_write` until `done`.

## Interface
- `WIDTH`, default 32: operand and result width. The only supported value is 32.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request an operation. Sampled only in IDLE.
- `funct3`  in  3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data`  in  WIDTH: dividend / multiplicand; captured when `start` is accepted.
- `rs2_data`  in  WIDTH: divisor / multiplier; captured when `start` is accepted.
- `busy`  out  1: operation accepted and not yet retired.
- `done`  out  1: one-cycle pulse; `result` is valid in this cycle.
- `result`  out  WIDTH: operation result; held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, FIN.
- IDLE, `start`=1:
  - Latch `funct3`.
  - Latch the magnitudes of the operands. Signed operands are rs1 for MULH/MULHSU/DIV/REM and rs2 for MULH/DIV/REM.
  - Latch the result-negate flag.
  - Clear the 6-bit iteration counter and go to CALC.
- IDLE, `start`=0: stay in IDLE.
- Special cases bypass CALC and go directly to FIN; the result is loaded at acceptance.
  - Divide by zero (rs2=0, funct3[2]=1): DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC, multiply: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- CALC exit: when the counter reaches 31, go to FIN.
- FIN:
  - Apply the negation. The product is negated if the operand signs differ. The quotient is negated if the signs differ. The remainder takes the dividend's sign.
  - Select the result: MUL takes product[31:0]. MULH/MULHSU/MULHU take product[63:32]. DIV/DIVU take the quotient. REM/REMU take the remainder.
  - Register `result`, pulse `done`, return to IDLE.
- All arithmetic is modulo 2^64 internally. Negation is two's complement of the full-width intermediate.
- `start` while `busy`=1 is ignored. Operand changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, internal registers 0.
- Reset takes priority over `start` and aborts any operation in flight.
- `start` is sampled at edge E0 (cycle 0). Latency depends on the path:
  - Normal path: `busy`=1 in cycles 1–33 and `done`=1 in cycle 33.
  - Special-case path: `busy`=1 and `done`=1 in cycle 1.
- `busy` falls together with `done`, at the end of the FIN cycle.
- A new `start` is accepted no earlier than the cycle after `done`, since the unit must be back in IDLE.
- `result` changes only on the FIN edge. It is stable from the `done` cycle until the FIN of the next operation.
- `done` never lasts more than one cycle. There is no back-pressure: the consumer must capture `result` while `done`=1, or read it later while it is held.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a combinational 64-bit product and skip CALC.
  - `done` is asserted in cycle 1.
  - Divide operations are unchanged at 33 cycles.
- `MULDIV_FAST_MUL_EN` undefined: all operations use the iterative path, 33-cycle latency.
- Results are bit-identical in both builds.

## Test plan
- MUL, rs1=7, rs2=6 -> `done` in cycle 33 (cycle 1 with the macro), `result`=42, `busy` low afterwards.
- MULH, rs1=0x80000000, rs2=0x80000000 -> 0x40000000. MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE.
- DIV, rs1=-7, rs2=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU, rs1=100, rs2=7 -> 14. REMU with the same operands -> 2.
- DIVU, rs2=0, rs1=0x1234 -> 0xFFFFFFFF in cycle 1. REMU with the same operands -> 0x1234. DIV, 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM of the same -> 0.
- `start` pulsed again in cycles 5 and 20 of a DIVU, with changed operands -> ignored. A single `done` in cycle 33 with the original result.
- `reset` asserted in cycle 10 of a DIV -> next cycle `busy`=0, `done`=0, `result`=0. A following MUL 3×3 returns 9 with normal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplies use radix-2 shift-add over 32 cycles; divides use restoring
// division over 32 cycles. Divide-by-zero and signed overflow resolve at
// acceptance and retire one cycle later.
// Optional build macro: MULDIV_FAST_MUL_EN -- multiplies use a single-cycle
// combinational product instead of the iterative datapath.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [5:0]       LAST_CNT = 6'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};

  // Registered state
  state_t             state_q,  state_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [WIDTH-1:0]   opa_q,    opa_d;     // multiplicand / dividend magnitude
  logic [WIDTH-1:0]   opb_q,    opb_d;     // multiplier / divisor magnitude
  logic               neg_q,    neg_d;     // negate final result
  logic [5:0]         cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;     // {partial product high, multiplier}
  logic [WIDTH-1:0]   rem_q,    rem_d;     // partial remainder (always < divisor)
  logic [WIDTH-1:0]   quo_q,    quo_d;     // dividend bits out, quotient bits in
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  // Acceptance-time decode
  logic               rs1_signed_s;
  logic               rs2_signed_s;
  logic [WIDTH-1:0]   mag1_s;
  logic [WIDTH-1:0]   mag2_s;
  logic               neg_s;
  logic               div_zero_s;
  logic               div_ovf_s;
  logic [WIDTH-1:0]   special_s;

  // One iteration of each datapath
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_shift_s;   // 33-bit partial remainder before trial subtract
  logic [WIDTH:0]     div_trial_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic [WIDTH-1:0]   quo_next_s;

  // Sign fix-up and result selection shared by every path into FIN.
  function automatic logic [WIDTH-1:0] finalize(
    input logic [2:0]         f3,
    input logic               neg,
    input logic [2*WIDTH-1:0] prod,
    input logic [WIDTH-1:0]   quo,
    input logic [WIDTH-1:0]   rem
  );
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   quo_f;
    logic [WIDTH-1:0]   rem_f;
    prod_f = neg ? (~prod + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod;
    quo_f  = neg ? (~quo + {{(WIDTH-1){1'b0}}, 1'b1}) : quo;
    rem_f  = neg ? (~rem + {{(WIDTH-1){1'b0}}, 1'b1}) : rem;
    case (f3)
      F_MUL:                     finalize = prod_f[WIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU: finalize = prod_f[2*WIDTH-1:WIDTH];
      F_DIV, F_DIVU:             finalize = quo_f;
      default:                   finalize = rem_f;
    endcase
  endfunction

  // Operand signedness, magnitudes, result sign and special-case detection
  always_comb begin
    rs1_signed_s = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                   (funct3 == F_DIV)  || (funct3 == F_REM);
    rs2_signed_s = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    if (rs1_signed_s && rs1_data[WIDTH-1]) begin
      mag1_s = ~rs1_data + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag1_s = rs1_data;
    end
    if (rs2_signed_s && rs2_data[WIDTH-1]) begin
      mag2_s = ~rs2_data + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag2_s = rs2_data;
    end
    case (funct3)
      F_MULH, F_DIV: neg_s = rs1_data[WIDTH-1] ^ rs2_data[WIDTH-1];
      F_MULHSU:      neg_s = rs1_data[WIDTH-1];
      F_REM:         neg_s = rs1_data[WIDTH-1];   // remainder follows dividend
      default:       neg_s = 1'b0;
    endcase
    div_zero_s = funct3[2] && (rs2_data == ZERO_W);
    div_ovf_s  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                 (rs1_data == MIN_W) && (rs2_data == ONES_W);
    if (div_zero_s) begin
      special_s = funct3[1] ? rs1_data : ONES_W;
    end else begin
      special_s = funct3[1] ? ZERO_W : MIN_W;
    end
  end

  // Single shift-add step and single restoring-division step
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opa_q} : {1'b0, ZERO_W});
    mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
    div_shift_s = {rem_q, quo_q[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opb_q};
    if (div_shift_s >= {1'b0, opb_q}) begin
      rem_next_s = div_trial_s[WIDTH-1:0];
      quo_next_s = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next_s = div_shift_s[WIDTH-1:0];
      quo_next_s = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // FSM next-state, datapath register updates and registered outputs
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          funct3_d = funct3;
          opa_d    = mag1_s;
          opb_d    = mag2_s;
          neg_d    = neg_s;
          cnt_d    = 6'd0;
          acc_d    = {ZERO_W, mag2_s};
          rem_d    = ZERO_W;
          quo_d    = mag1_s;
          if (div_zero_s || div_ovf_s) begin
            result_d = special_s;
            state_d  = S_FIN;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!funct3[2]) begin
            result_d = finalize(funct3, neg_s,
                                {ZERO_W, mag1_s} * {ZERO_W, mag2_s},
                                ZERO_W, ZERO_W);
            state_d  = S_FIN;
          end
`endif
          else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (funct3_q[2]) begin
          rem_d = rem_next_s;
          quo_d = quo_next_s;
        end else begin
          acc_d = mul_next_s;
        end
        if (cnt_q == LAST_CNT) begin
          // Final iteration: fold sign fix-up in so result is valid in FIN.
          result_d = finalize(funct3_q, neg_q, mul_next_s, quo_next_s, rem_next_s);
          state_d  = S_FIN;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'd0;
      opa_q    <= ZERO_W;
      opb_q    <= ZERO_W;
      neg_q    <= 1'b0;
      cnt_q    <= 6'd0;
      acc_q    <= {2*WIDTH{1'b0}};
      rem_q    <= ZERO_W;
      quo_q    <= ZERO_W;
      result_q <= ZERO_W;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected result and
// expected done cycle per accepted operation; a monitor checks on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit noise_en = 1'b0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t expq[$];

  logic [31:0] hold_ref = 32'd0;
  logic        prev_done = 1'b0;
  logic        chk_idle = 1'b0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && (b == 32'd0)) return 1;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (FAST && !f3[2]) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      4: return 32'd0 - ($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; waits for IDLE then presents one start for one edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit use_exp, input logic [31:0] exp_res);
    int guard = 0;
    exp_t e;
    while (busy && guard < 200) begin
      if (noise_en) begin
        start    = ($urandom % 5 == 0);
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL idle_wait_timeout got=busy exp=idle");
    end
    start    = 1'b1;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    e.res = use_exp ? exp_res : ref_result(f3, a, b);
    e.due = cyc + ref_latency(f3, a, b);
    expq.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    rs1_data = $urandom;
    rs2_data = $urandom;
    funct3   = 3'($urandom);
  endtask

  // Monitor: compares on done, checks result hold and busy behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_ref  = 32'd0;
      chk_idle  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (chk_idle) begin
        check("busy_low_after_done", {63'd0, busy}, 64'd0);
        chk_idle = 1'b0;
      end
      if (done) begin
        check("done_single_cycle", {63'd0, prev_done}, 64'd0);
        check("busy_with_done", {63'd0, busy}, 64'd1);
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done got=1 exp=0 (cycle %0d)", cyc);
        end else begin
          e = expq.pop_front();
          check("result", {32'd0, result}, {32'd0, e.res});
          check("latency", 64'(cyc), 64'(e.due));
        end
        hold_ref = result;
        chk_idle = 1'b1;
      end else begin
        check("result_hold", {32'd0, result}, {32'd0, hold_ref});
      end
      prev_done = done;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    expq.delete();
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    @(negedge clk);
    do_reset();

    // Directed cases with hand-derived expectations
    issue(3'd0, 32'd7, 32'd6, 1'b1, 32'd42);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
    issue(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
    issue(3'd7, 32'd100, 32'd7, 1'b1, 32'd2);
    issue(3'd5, 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF);
    issue(3'd7, 32'h1234, 32'd0, 1'b1, 32'h1234);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0);

    // start pulses during a DIVU with different operands are ignored
    issue(3'd5, 32'd1000000, 32'd3, 1'b1, 32'd333333);
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1; funct3 = 3'd7; rs1_data = 32'd9; rs2_data = 32'd0;
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of a DIV aborts it; next MUL runs normally
    issue(3'd4, 32'd1000, 32'd7, 1'b0, 32'd0);
    repeat (8) @(negedge clk);
    do_reset();
    issue(3'd0, 32'd3, 32'd3, 1'b1, 32'd9);

    // Randomized operations with ignored start noise while busy
    noise_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom % 4 == 0) begin
        int gap;
        gap = $urandom_range(1, 3);
        while (busy) @(negedge clk);
        start = 1'b0;
        repeat (gap) @(negedge clk);
      end
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b0, 32'd0);
    end
    noise_en = 1'b0;

    guard = 0;
    while (expq.size() != 0 && guard < 200) begin
      start = 1'b0;
      @(negedge clk);
      guard++;
    end
    if (expq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0", expq.size());
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
